// File: rtl/mlp_sequencer.sv
// mlp_sequencer: time-multiplexed controller for a 784-30-10 MLP built around one 8x8 signed MAC.
// Streams pixel/weight/bias memories, sends each saturated zed to an external sigmoid LUT,
// buffers hidden activations, then runs the output layer and reports the argmax digit.
module mlp_sequencer #(
    parameter int PIX_N = 784,
    parameter int HL_N  = 30,
    parameter int OL_N  = 10,
    parameter int RES   = 8,
    parameter int FRAC  = 5,
    parameter int ACC_W = 24
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [3:0]     digit,
    output logic [RES-1:0] max_act,
    output logic [9:0]     pix_addr,
    input  logic [RES-1:0] pix_data,
    output logic [14:0]    w_addr,
    input  logic [RES-1:0] w_data,
    output logic [5:0]     b_addr,
    input  logic [RES-1:0] b_data,
    output logic [4:0]     hid_addr,
    output logic           hid_we,
    output logic [RES-1:0] hid_wdata,
    input  logic [RES-1:0] hid_rdata,
    output logic [RES-1:0] zed,
    output logic           zed_valid,
    input  logic [RES-1:0] act,
    output logic           out_we,
    output logic [3:0]     out_idx
);

    localparam int PROD_W = 2 * RES;
    localparam int SUM_W  = ACC_W + 1;

    localparam logic [9:0] I_LAST_HL = 10'(PIX_N - 1);
    localparam logic [9:0] I_LAST_OL = 10'(HL_N - 1);
    localparam logic [4:0] N_LAST_HL = 5'(HL_N - 1);
    localparam logic [4:0] N_LAST_OL = 5'(OL_N - 1);
    localparam logic [5:0] OL_B_BASE = 6'(HL_N);

    localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'((2 ** (RES - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO   = ~SAT_HI;
    localparam logic signed [RES-1:0]   MAX_INIT = {1'b1, {(RES - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HL_MAC,
        S_HL_DRAIN,
        S_HL_WB,
        S_OL_MAC,
        S_OL_DRAIN,
        S_OL_WB,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [9:0]                i_q, i_d;
    logic [4:0]                n_q, n_d;
    logic [14:0]               w_addr_q, w_addr_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      mac_v_q, mac_v_d;
    logic signed [RES-1:0]     max_q, max_d;
    logic [3:0]                arg_q, arg_d;
    logic [3:0]                digit_q, digit_d;
    logic [RES-1:0]            max_act_q, max_act_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic signed [PROD_W-1:0]  op_ext, w_ext, prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [SUM_W-1:0]   acc_ext, bias_ext, zsum;
    logic signed [RES-1:0]     zed_sat;
    logic                      ol_phase;

    // State and datapath registers; reset returns to IDLE and clears all results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            n_q       <= '0;
            w_addr_q  <= '0;
            acc_q     <= '0;
            mac_v_q   <= 1'b0;
            max_q     <= MAX_INIT;
            arg_q     <= '0;
            digit_q   <= '0;
            max_act_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            n_q       <= n_d;
            w_addr_q  <= w_addr_d;
            acc_q     <= acc_d;
            mac_v_q   <= mac_v_d;
            max_q     <= max_d;
            arg_q     <= arg_d;
            digit_q   <= digit_d;
            max_act_q <= max_act_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: per neuron K MAC cycles, one drain, one write-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_HL_MAC;
            S_HL_MAC:   if (i_q == I_LAST_HL) state_d = S_HL_DRAIN;
            S_HL_DRAIN: state_d = S_HL_WB;
            S_HL_WB:    state_d = (n_q == N_LAST_HL) ? S_OL_MAC : S_HL_MAC;
            S_OL_MAC:   if (i_q == I_LAST_OL) state_d = S_OL_DRAIN;
            S_OL_DRAIN: state_d = S_OL_WB;
            S_OL_WB:    state_d = (n_q == N_LAST_OL) ? S_DONE : S_OL_MAC;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // MAC product and saturated pre-activation from the accumulator and bias.
    always_comb begin
        ol_phase = (state_q == S_OL_MAC) || (state_q == S_OL_DRAIN);
        op_ext   = ol_phase ? {{RES{hid_rdata[RES-1]}}, hid_rdata}
                            : {{RES{pix_data[RES-1]}}, pix_data};
        w_ext    = {{RES{w_data[RES-1]}}, w_data};
        prod     = op_ext * w_ext;
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        acc_ext  = {acc_q[ACC_W-1], acc_q};
        bias_ext = {{(SUM_W - RES){b_data[RES-1]}}, b_data};
        zsum     = (acc_ext >>> FRAC) + bias_ext;
        if (zsum > SAT_HI) begin
            zed_sat = SAT_HI[RES-1:0];
        end else if (zsum < SAT_LO) begin
            zed_sat = SAT_LO[RES-1:0];
        end else begin
            zed_sat = zsum[RES-1:0];
        end
    end

    // Counter, accumulator, argmax and handshake updates.
    // Weights of both layers are laid out back to back, so one running address covers all MAC cycles.
    always_comb begin
        i_d       = i_q;
        n_d       = n_q;
        w_addr_d  = w_addr_q;
        max_d     = max_q;
        arg_d     = arg_q;
        digit_d   = digit_q;
        max_act_d = max_act_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mac_v_d   = (state_q == S_HL_MAC) || (state_q == S_OL_MAC);
        acc_d     = mac_v_q ? (acc_q + prod_ext) : acc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    i_d      = '0;
                    n_d      = '0;
                    w_addr_d = '0;
                    max_d    = MAX_INIT;
                    arg_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            S_HL_MAC: begin
                i_d      = (i_q == I_LAST_HL) ? '0 : i_q + 10'd1;
                w_addr_d = w_addr_q + 15'd1;
            end
            S_OL_MAC: begin
                i_d      = (i_q == I_LAST_OL) ? '0 : i_q + 10'd1;
                w_addr_d = w_addr_q + 15'd1;
            end
            S_HL_WB: begin
                acc_d = '0;
                n_d   = (n_q == N_LAST_HL) ? '0 : n_q + 5'd1;
            end
            S_OL_WB: begin
                acc_d = '0;
                n_d   = (n_q == N_LAST_OL) ? '0 : n_q + 5'd1;
                if ($signed(act) > max_q) begin
                    max_d = $signed(act);
                    arg_d = n_q[3:0];
                end
            end
            S_DONE: begin
                digit_d   = arg_q;
                max_act_d = max_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
            end
            default: ;
        endcase
    end

    // Output decode: memory addresses, LUT interface and write strobes per state.
    always_comb begin
        busy      = busy_q;
        done      = done_q;
        digit     = digit_q;
        max_act   = max_act_q;
        pix_addr  = '0;
        w_addr    = '0;
        b_addr    = '0;
        hid_addr  = '0;
        hid_we    = 1'b0;
        hid_wdata = act;
        zed       = '0;
        zed_valid = 1'b0;
        out_we    = 1'b0;
        out_idx   = '0;
        case (state_q)
            S_HL_MAC: begin
                pix_addr = i_q;
                w_addr   = w_addr_q;
                b_addr   = {1'b0, n_q};
            end
            S_HL_DRAIN: b_addr = {1'b0, n_q};
            S_HL_WB: begin
                b_addr    = {1'b0, n_q};
                zed       = zed_sat;
                zed_valid = 1'b1;
                hid_we    = 1'b1;
                hid_addr  = n_q;
            end
            S_OL_MAC: begin
                w_addr   = w_addr_q;
                hid_addr = i_q[4:0];
                b_addr   = OL_B_BASE + {1'b0, n_q};
            end
            S_OL_DRAIN: b_addr = OL_B_BASE + {1'b0, n_q};
            S_OL_WB: begin
                b_addr    = OL_B_BASE + {1'b0, n_q};
                zed       = zed_sat;
                zed_valid = 1'b1;
                out_we    = 1'b1;
                out_idx   = n_q[3:0];
            end
            default: ;
        endcase
    end

endmodule
